// File: rtl/csr_unit.sv
// csr_unit -- machine-mode CSR file for the dtcore32 pipeline.
//
// Serves CSR instructions at commit (write / set / clear), stacks the
// mstatus interrupt enable across trap entry and mret, computes the
// (optionally vectored) trap handler address and runs the cycle, retired
// instruction and hardware performance counters.
//
// Optional feature macro: CSR_HPM_EN. When defined, NUM_HPM counter/event
// pairs (mhpmcounter3.., mhpmevent3..) and their mcountinhibit bits exist.
// When undefined, the HPM address ranges read as zero, are legal, ignore
// writes, and event_i is unused.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   csr_addr_i/op_i      CSR address and operation (00 none, 01 write,
//   csr_wdata_i          10 set, 11 clear) with the operand value
//   csr_we_i             commit strobe for the CSR operation
//   csr_rdata_o          pre-update value at csr_addr_i (combinational)
//   csr_illegal_o        unimplemented address or modify of read-only CSR
//   retire_i             one instruction retires this cycle
//   event_i              per-cycle event pulses for the HPM counters
//   trap_valid_i, trap_cause_i, trap_pc_i, trap_tval_i   trap entry
//   mret_i               mret commits
//   trap_target_o        handler address from mtvec and registered mcause
//   epc_o                mepc for the mret redirect
//   mie_o                mstatus.MIE
module csr_unit #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [11:0]           csr_addr_i,
  input  logic [1:0]            csr_op_i,
  input  logic [31:0]           csr_wdata_i,
  input  logic                  csr_we_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_illegal_o,
  input  logic                  retire_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  trap_valid_i,
  input  logic [31:0]           trap_cause_i,
  input  logic [31:0]           trap_pc_i,
  input  logic [31:0]           trap_tval_i,
  input  logic                  mret_i,
  output logic [31:0]           trap_target_o,
  output logic [31:0]           epc_o,
  output logic                  mie_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Address bits [11:5] select a 32-entry window: counters, counter high
  // halves, and the mcountinhibit/mhpmevent block.
  localparam logic [6:0] WIN_CNT_LO = 7'h58;
  localparam logic [6:0] WIN_CNT_HI = 7'h5C;
  localparam logic [6:0] WIN_EVENT  = 7'h19;

  logic                 mie, mpie;
  logic [31:0]          mtvec, mscratch, mepc, mcause, mtval, inhibit;
  logic [CNT_WIDTH-1:0] mcycle, minstret;
  logic [31:0]          mstatus_val, rdata, new_val, tvec_base;
  logic                 implemented, wr_en;
  logic [6:0]           addr_win;
  logic [4:0]           addr_idx;

  assign addr_win = csr_addr_i[11:5];
  assign addr_idx = csr_addr_i[4:0];

  // MPP is hardwired to machine mode, so it always reads 11.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};

`ifdef CSR_HPM_EN
  localparam int HPM_SLOTS = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] INHIBIT_MASK =
    32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [CNT_WIDTH-1:0] hpm_cnt [HPM_SLOTS];
  logic [4:0]           hpm_evt [HPM_SLOTS];
  logic [HPM_SLOTS-1:0] hpm_inc;
  logic [31:0]          event_pad;

  // Zero-padding to 32 bits lets a 5-bit event selector index the bus
  // directly; selectors above NUM_EVENTS land on the zero padding.
  assign event_pad = 32'(event_i);

  always_comb begin
    hpm_inc = '0;
    for (int n = 0; n < NUM_HPM; n++) begin
      hpm_inc[n] = (hpm_evt[n] != 5'd0) && event_pad[hpm_evt[n] - 5'd1] &&
                   !inhibit[n+3];
    end
  end
`else
  localparam logic [31:0] INHIBIT_MASK = 32'h5;
  localparam int unused_num_hpm = NUM_HPM;
  logic unused_event;
  assign unused_event = ^event_i;
`endif

  // Read mux; anything not decoded here is unimplemented and illegal.
  always_comb begin
    rdata       = 32'h0;
    implemented = 1'b1;
    case (csr_addr_i)
      12'h300: rdata = mstatus_val;
      12'h305: rdata = mtvec;
      12'h340: rdata = mscratch;
      12'h341: rdata = mepc;
      12'h342: rdata = mcause;
      12'h343: rdata = mtval;
      12'h320: rdata = inhibit;
      12'hB00: rdata = mcycle[31:0];
      12'hB80: rdata = 32'(mcycle[CNT_WIDTH-1:32]);
      12'hB02: rdata = minstret[31:0];
      12'hB82: rdata = 32'(minstret[CNT_WIDTH-1:32]);
      default: begin
        implemented = 1'b0;
`ifdef CSR_HPM_EN
        for (int n = 0; n < NUM_HPM; n++) begin
          if (32'(addr_idx) == n + 3) begin
            if (addr_win == WIN_CNT_LO) begin
              rdata       = hpm_cnt[n][31:0];
              implemented = 1'b1;
            end else if (addr_win == WIN_CNT_HI) begin
              rdata       = 32'(hpm_cnt[n][CNT_WIDTH-1:32]);
              implemented = 1'b1;
            end else if (addr_win == WIN_EVENT) begin
              rdata       = {27'b0, hpm_evt[n]};
              implemented = 1'b1;
            end
          end
        end
`else
        // Without HPM support the whole HPM range is a legal read-zero hole.
        if ((addr_win == WIN_CNT_LO || addr_win == WIN_CNT_HI ||
             addr_win == WIN_EVENT) && addr_idx >= 5'd3) begin
          implemented = 1'b1;
        end
`endif
      end
    endcase
  end

  assign csr_rdata_o   = rdata;
  assign csr_illegal_o = !implemented ||
                         ((csr_op_i != 2'b00) && (csr_addr_i[11:10] == 2'b11));

  always_comb begin
    case (csr_op_i)
      2'b01:   new_val = csr_wdata_i;
      2'b10:   new_val = rdata | csr_wdata_i;
      2'b11:   new_val = rdata & ~csr_wdata_i;
      default: new_val = rdata;
    endcase
  end

  // A trap or an mret in the same cycle suppresses the CSR operation.
  assign wr_en = csr_we_i && (csr_op_i != 2'b00) && !csr_illegal_o &&
                 !trap_valid_i && !mret_i;

  // A software write to either half beats the increment in that cycle.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 wr_lo,
    input logic                 wr_hi,
    input logic                 inc,
    input logic [31:0]          val
  );
    logic [CNT_WIDTH-1:0] res;
    res = cur;
    if (wr_lo)      res[31:0]           = val;
    else if (wr_hi) res[CNT_WIDTH-1:32] = val[CNT_WIDTH-33:0];
    else if (inc)   res                 = cur + CNT_ONE;
    return res;
  endfunction

  // Trap entry and mret take precedence over software writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= 32'h0;
      mscratch <= 32'h0;
      mepc     <= 32'h0;
      mcause   <= 32'h0;
      mtval    <= 32'h0;
      inhibit  <= 32'h0;
    end else if (trap_valid_i) begin
      mepc   <= trap_pc_i & ~32'h3;
      mcause <= trap_cause_i;
      mtval  <= trap_tval_i;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_i) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (wr_en) begin
      case (csr_addr_i)
        12'h300: begin
          mie  <= new_val[3];
          mpie <= new_val[7];
        end
        12'h305: mtvec    <= new_val & ~32'h2;
        12'h340: mscratch <= new_val;
        12'h341: mepc     <= new_val & ~32'h3;
        12'h342: mcause   <= new_val;
        12'h343: mtval    <= new_val;
        12'h320: inhibit  <= new_val & INHIBIT_MASK;
        default: ;
      endcase
    end
  end

  // Inhibit bits are registered, so an mcountinhibit write first affects
  // the increment of the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= cnt_next(mcycle, wr_en && csr_addr_i == 12'hB00,
                           wr_en && csr_addr_i == 12'hB80, !inhibit[0], new_val);
      minstret <= cnt_next(minstret, wr_en && csr_addr_i == 12'hB02,
                           wr_en && csr_addr_i == 12'hB82,
                           retire_i && !inhibit[2], new_val);
    end
  end

`ifdef CSR_HPM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < NUM_HPM; n++) begin
        hpm_cnt[n] <= '0;
        hpm_evt[n] <= 5'd0;
      end
    end else begin
      for (int n = 0; n < NUM_HPM; n++) begin
        hpm_cnt[n] <= cnt_next(hpm_cnt[n],
                               wr_en && addr_win == WIN_CNT_LO && 32'(addr_idx) == n + 3,
                               wr_en && addr_win == WIN_CNT_HI && 32'(addr_idx) == n + 3,
                               hpm_inc[n], new_val);
        if (wr_en && addr_win == WIN_EVENT && 32'(addr_idx) == n + 3)
          hpm_evt[n] <= new_val[4:0];
      end
    end
  end
`endif

  // Vectored mode only applies to interrupts; exceptions use the base.
  assign tvec_base     = {mtvec[31:2], 2'b00};
  assign trap_target_o = (mtvec[0] && mcause[31]) ?
                         tvec_base + {25'b0, mcause[4:0], 2'b00} : tvec_base;
  assign epc_o         = mepc;
  assign mie_o         = mie;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit -- directed self-checking bench for csr_unit.
//
// Each test_* task drives one scenario and compares outputs against
// hand-computed constants. Inputs change and outputs are sampled on the
// falling clock edge (plus small delays), away from the rising edge.
// HPM expectations follow whether CSR_HPM_EN is defined for the build.
`timescale 1ns/1ps
module tb_csr_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [11:0] csr_addr_i = 12'h0;
  logic [1:0]  csr_op_i = 2'b00;
  logic [31:0] csr_wdata_i = 32'h0;
  logic        csr_we_i = 1'b0;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        retire_i = 1'b0;
  logic [7:0]  event_i = 8'h0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_cause_i = 32'h0;
  logic [31:0] trap_pc_i = 32'h0;
  logic [31:0] trap_tval_i = 32'h0;
  logic        mret_i = 1'b0;
  logic [31:0] trap_target_o;
  logic [31:0] epc_o;
  logic        mie_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] rd;

  csr_unit #(.NUM_HPM(4), .CNT_WIDTH(64), .NUM_EVENTS(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i),
    .csr_we_i(csr_we_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .retire_i(retire_i), .event_i(event_i),
    .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .mret_i(mret_i),
    .trap_target_o(trap_target_o), .epc_o(epc_o), .mie_o(mie_o)
  );

  always #50 clk_i = ~clk_i;

  // Drive one committed CSR op through a rising edge; returns on the
  // following falling edge with the result visible.
  task automatic do_op(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr_i = a; csr_op_i = op; csr_wdata_i = d; csr_we_i = 1'b1;
    @(negedge clk_i);
    csr_op_i = 2'b00; csr_wdata_i = 32'h0; csr_we_i = 1'b0;
  endtask

  // Combinational read without any operation.
  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    csr_addr_i = a; csr_op_i = 2'b00; csr_we_i = 1'b0;
    #1;
    d = csr_rdata_o;
  endtask

  // Take one trap through a rising edge.
  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    trap_valid_i = 1'b1; trap_cause_i = cause; trap_pc_i = pc; trap_tval_i = tval;
    @(negedge clk_i);
    trap_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    peek(12'h300, rd);
    vectors++; if (rd !== 32'h0000_1800) begin miscompares++; $display("[TB] FAIL reset_mstatus: got %h expected %h", rd, 32'h0000_1800); end
    vectors++; if (mie_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mie: got %b expected 0", mie_o); end
    vectors++; if (epc_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_epc: got %h expected 0", epc_o); end
    vectors++; if (trap_target_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_target: got %h expected 0", trap_target_o); end
    peek(12'h305, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mtvec: got %h expected 0", rd); end
    rst_ni = 1'b1;
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mcycle0: got %h expected 0", rd); end
    @(negedge clk_i);
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("[TB] FAIL reset_mcycle1: got %h expected 1", rd); end
  endtask

  task automatic test_mstatus_trap();
    do_op(12'h300, 2'b01, 32'h0000_0008);
    peek(12'h300, rd);
    vectors++; if (rd !== 32'h0000_1808) begin miscompares++; $display("[TB] FAIL mstatus_write: got %h expected %h", rd, 32'h0000_1808); end
    vectors++; if (mie_o !== 1'b1) begin miscompares++; $display("[TB] FAIL mie_set: got %b expected 1", mie_o); end
    do_trap(32'h8000_0007, 32'h0000_0106, 32'h0000_DEAD);
    peek(12'h341, rd);
    vectors++; if (rd !== 32'h0000_0104) begin miscompares++; $display("[TB] FAIL trap_mepc: got %h expected %h", rd, 32'h0000_0104); end
    vectors++; if (epc_o !== 32'h0000_0104) begin miscompares++; $display("[TB] FAIL trap_epc_o: got %h expected %h", epc_o, 32'h0000_0104); end
    peek(12'h300, rd);
    vectors++; if (rd !== 32'h0000_1880) begin miscompares++; $display("[TB] FAIL trap_mstatus: got %h expected %h", rd, 32'h0000_1880); end
    vectors++; if (mie_o !== 1'b0) begin miscompares++; $display("[TB] FAIL trap_mie: got %b expected 0", mie_o); end
    peek(12'h342, rd);
    vectors++; if (rd !== 32'h8000_0007) begin miscompares++; $display("[TB] FAIL trap_mcause: got %h expected %h", rd, 32'h8000_0007); end
    peek(12'h343, rd);
    vectors++; if (rd !== 32'h0000_DEAD) begin miscompares++; $display("[TB] FAIL trap_mtval: got %h expected %h", rd, 32'h0000_DEAD); end
    mret_i = 1'b1;
    @(negedge clk_i);
    mret_i = 1'b0;
    peek(12'h300, rd);
    vectors++; if (rd !== 32'h0000_1888) begin miscompares++; $display("[TB] FAIL mret_mstatus: got %h expected %h", rd, 32'h0000_1888); end
    vectors++; if (mie_o !== 1'b1) begin miscompares++; $display("[TB] FAIL mret_mie: got %b expected 1", mie_o); end
  endtask

  task automatic test_trap_target();
    do_op(12'h305, 2'b01, 32'h0000_1003);
    peek(12'h305, rd);
    vectors++; if (rd !== 32'h0000_1001) begin miscompares++; $display("[TB] FAIL mtvec_mask: got %h expected %h", rd, 32'h0000_1001); end
    do_trap(32'h8000_0003, 32'h0000_0200, 32'h0);
    vectors++; if (trap_target_o !== 32'h0000_100C) begin miscompares++; $display("[TB] FAIL target_vectored: got %h expected %h", trap_target_o, 32'h0000_100C); end
    do_trap(32'h0000_0002, 32'h0000_0300, 32'h0);
    vectors++; if (trap_target_o !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL target_exception: got %h expected %h", trap_target_o, 32'h0000_1000); end
  endtask

  task automatic test_set_clear();
    do_op(12'h340, 2'b01, 32'h0000_F0F0);
    do_op(12'h340, 2'b10, 32'h0000_000F);
    peek(12'h340, rd);
    vectors++; if (rd !== 32'h0000_F0FF) begin miscompares++; $display("[TB] FAIL mscratch_set: got %h expected %h", rd, 32'h0000_F0FF); end
    do_op(12'h340, 2'b11, 32'h0000_00F0);
    peek(12'h340, rd);
    vectors++; if (rd !== 32'h0000_F00F) begin miscompares++; $display("[TB] FAIL mscratch_clear: got %h expected %h", rd, 32'h0000_F00F); end
    do_op(12'h341, 2'b01, 32'hFFFF_FFFF);
    peek(12'h341, rd);
    vectors++; if (rd !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL mepc_mask: got %h expected %h", rd, 32'hFFFF_FFFC); end
    vectors++; if (epc_o !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL epc_o_write: got %h expected %h", epc_o, 32'hFFFF_FFFC); end
  endtask

  task automatic test_inhibit_mcycle();
    logic [31:0] mask_exp;
`ifdef CSR_HPM_EN
    mask_exp = 32'h0000_007D;
`else
    mask_exp = 32'h0000_0005;
`endif
    do_op(12'h320, 2'b01, 32'hFFFF_FFFF);
    peek(12'h320, rd);
    vectors++; if (rd !== mask_exp) begin miscompares++; $display("[TB] FAIL inhibit_mask: got %h expected %h", rd, mask_exp); end
    do_op(12'h320, 2'b01, 32'h0000_0001);
    do_op(12'hB00, 2'b01, 32'h0000_0100);
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h0000_0100) begin miscompares++; $display("[TB] FAIL mcycle_write: got %h expected %h", rd, 32'h0000_0100); end
    @(negedge clk_i);
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h0000_0100) begin miscompares++; $display("[TB] FAIL mcycle_inhibited: got %h expected %h", rd, 32'h0000_0100); end
    do_op(12'h320, 2'b11, 32'h0000_0001);
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h0000_0100) begin miscompares++; $display("[TB] FAIL inhibit_clear_delay: got %h expected %h", rd, 32'h0000_0100); end
    @(negedge clk_i);
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h0000_0101) begin miscompares++; $display("[TB] FAIL mcycle_resume: got %h expected %h", rd, 32'h0000_0101); end
    do_op(12'hB80, 2'b01, 32'h0000_0007);
    peek(12'hB80, rd);
    vectors++; if (rd !== 32'h0000_0007) begin miscompares++; $display("[TB] FAIL mcycleh_write: got %h expected %h", rd, 32'h0000_0007); end
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h0000_0101) begin miscompares++; $display("[TB] FAIL mcycleh_inc_lost: got %h expected %h", rd, 32'h0000_0101); end
  endtask

  task automatic test_minstret();
    do_op(12'hB02, 2'b01, 32'hFFFF_FFFF);
    do_op(12'hB82, 2'b01, 32'h0000_0000);
    retire_i = 1'b1;
    peek(12'hB02, rd);
    vectors++; if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL minstret_pre_inc: got %h expected %h", rd, 32'hFFFF_FFFF); end
    @(negedge clk_i);
    retire_i = 1'b0;
    peek(12'hB02, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL minstret_wrap_lo: got %h expected 0", rd); end
    peek(12'hB82, rd);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("[TB] FAIL minstret_wrap_hi: got %h expected 1", rd); end
    retire_i = 1'b1;
    do_op(12'hB02, 2'b01, 32'h0000_0055);
    retire_i = 1'b0;
    peek(12'hB02, rd);
    vectors++; if (rd !== 32'h0000_0055) begin miscompares++; $display("[TB] FAIL minstret_write_wins: got %h expected %h", rd, 32'h0000_0055); end
  endtask

`ifdef CSR_HPM_EN
  task automatic test_hpm();
    do_op(12'h323, 2'b01, 32'h0000_0022);
    peek(12'h323, rd);
    vectors++; if (rd !== 32'h0000_0002) begin miscompares++; $display("[TB] FAIL hpmevent_mask: got %h expected %h", rd, 32'h0000_0002); end
    event_i = 8'h02;
    repeat (5) @(negedge clk_i);
    event_i = 8'h00;
    peek(12'hB03, rd);
    vectors++; if (rd !== 32'h5) begin miscompares++; $display("[TB] FAIL hpm_count: got %h expected 5", rd); end
    do_op(12'h320, 2'b10, 32'h0000_0008);
    event_i = 8'h02;
    repeat (3) @(negedge clk_i);
    event_i = 8'h00;
    peek(12'hB03, rd);
    vectors++; if (rd !== 32'h5) begin miscompares++; $display("[TB] FAIL hpm_inhibited: got %h expected 5", rd); end
    do_op(12'h320, 2'b11, 32'h0000_0008);
    do_op(12'h323, 2'b01, 32'h0000_0000);
    event_i = 8'hFF;
    repeat (2) @(negedge clk_i);
    event_i = 8'h00;
    peek(12'hB03, rd);
    vectors++; if (rd !== 32'h5) begin miscompares++; $display("[TB] FAIL hpm_event0: got %h expected 5", rd); end
    peek(12'hB83, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL hpm_high: got %h expected 0", rd); end
  endtask
`else
  task automatic test_hpm();
    do_op(12'hB03, 2'b01, 32'h0000_1234);
    do_op(12'h323, 2'b01, 32'h0000_0002);
    event_i = 8'h02;
    repeat (3) @(negedge clk_i);
    event_i = 8'h00;
    peek(12'hB03, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL hpm_off_counter: got %h expected 0", rd); end
    peek(12'h323, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL hpm_off_event: got %h expected 0", rd); end
    csr_addr_i = 12'hB9F; csr_op_i = 2'b01; #1;
    vectors++; if (csr_illegal_o !== 1'b0) begin miscompares++; $display("[TB] FAIL hpm_off_legal: got %b expected 0", csr_illegal_o); end
    csr_op_i = 2'b00;
  endtask
`endif

  task automatic test_illegal_priority();
    csr_addr_i = 12'hC00; csr_op_i = 2'b01; #1;
    vectors++; if (csr_illegal_o !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_ro: got %b expected 1", csr_illegal_o); end
    csr_addr_i = 12'hF11; csr_op_i = 2'b00; #1;
    vectors++; if (csr_illegal_o !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_unimpl: got %b expected 1", csr_illegal_o); end
    csr_addr_i = 12'hB01; #1;
    vectors++; if (csr_illegal_o !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_time: got %b expected 1", csr_illegal_o); end
    csr_addr_i = 12'hB00; csr_op_i = 2'b01; #1;
    vectors++; if (csr_illegal_o !== 1'b0) begin miscompares++; $display("[TB] FAIL legal_mcycle: got %b expected 0", csr_illegal_o); end
    csr_op_i = 2'b00;
    // mstatus 0x1808 then mret racing a clear of MIE: mret must win.
    do_op(12'h300, 2'b01, 32'h0000_0008);
    mret_i = 1'b1;
    do_op(12'h300, 2'b11, 32'h0000_0008);
    mret_i = 1'b0;
    peek(12'h300, rd);
    vectors++; if (rd !== 32'h0000_1880) begin miscompares++; $display("[TB] FAIL mret_over_csr: got %h expected %h", rd, 32'h0000_1880); end
    // Trap, mret and a CSR write together: only the trap acts.
    do_op(12'h340, 2'b01, 32'h0000_A5A5);
    mret_i = 1'b1;
    trap_valid_i = 1'b1; trap_cause_i = 32'h5; trap_pc_i = 32'h200; trap_tval_i = 32'h0;
    do_op(12'h340, 2'b01, 32'h0000_1234);
    trap_valid_i = 1'b0; mret_i = 1'b0;
    peek(12'h340, rd);
    vectors++; if (rd !== 32'h0000_A5A5) begin miscompares++; $display("[TB] FAIL trap_blocks_csr: got %h expected %h", rd, 32'h0000_A5A5); end
    peek(12'h300, rd);
    vectors++; if (rd !== 32'h0000_1800) begin miscompares++; $display("[TB] FAIL trap_over_mret: got %h expected %h", rd, 32'h0000_1800); end
    vectors++; if (epc_o !== 32'h0000_0200) begin miscompares++; $display("[TB] FAIL trap_epc2: got %h expected %h", epc_o, 32'h0000_0200); end
  endtask

  task automatic test_reset_midop();
    csr_addr_i = 12'h340; csr_op_i = 2'b01; csr_wdata_i = 32'h0000_7777; csr_we_i = 1'b1;
    #10 rst_ni = 1'b0;
    #1;
    csr_op_i = 2'b00; csr_we_i = 1'b0; csr_wdata_i = 32'h0;
    peek(12'h340, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL midreset_mscratch: got %h expected 0", rd); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    peek(12'hB02, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL midreset_minstret: got %h expected 0", rd); end
    @(negedge clk_i);
    peek(12'hB00, rd);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("[TB] FAIL midreset_mcycle: got %h expected 1", rd); end
    peek(12'hB80, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL midreset_mcycleh: got %h expected 0", rd); end
  endtask

  initial begin
    test_reset();
    test_mstatus_trap();
    test_trap_target();
    test_set_clear();
    test_inhibit_mcycle();
    test_minstret();
    test_hpm();
    test_illegal_priority();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
